// File: rtl/xnor_pop_pkg.sv
// Shared widths and helpers for the streaming XNOR-popcount neuron engine
// and the next-layer packer that consumes its results.
package xnor_pop_pkg;

  localparam int RES_SUM_W = 16;
  localparam int RES_CNT_W = 8;

  typedef struct packed {
    logic [RES_CNT_W-1:0] beats;
    logic                 sat;
    logic [RES_SUM_W-1:0] sum;
    logic                 hit;
  } result_t;

  // Popcount of N bits spans 0..N inclusive.
  function automatic int pop_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Returns {overflow, sum clamped to w bits of all-ones}.
  function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int w);
    logic [64:0] s;
    logic [63:0] mx;
    mx = (64'd1 << w) - 64'd1;
    s  = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, mx}) return {1'b1, mx};
    return {1'b0, s[63:0]};
  endfunction

endpackage

// File: rtl/xnor_popcount_masked.sv
// Combinational masked XNOR popcount: 3-bit group counts reduced by a
// pairwise adder tree.
module xnor_popcount_masked
  import xnor_pop_pkg::*;
#(
  parameter int N = 128
) (
  input  logic [N-1:0]          i_x,
  input  logic [N-1:0]          i_w,
  input  logic [N-1:0]          i_mask,
  output logic [pop_w(N)-1:0]   o_pop
);

  localparam int PW = pop_w(N);
  localparam int NG = (N + 2) / 3;

  logic [3*NG-1:0] w_bits;
  logic [PW-1:0]   w_sum [NG];

  // Pad to a whole number of groups; pad bits are zero so they never count.
  assign w_bits = (3*NG)'(i_mask & ~(i_x ^ i_w));

  always_comb begin
    for (int g = 0; g < NG; g++)
      w_sum[g] = PW'({1'b0, w_bits[3*g]} + {1'b0, w_bits[3*g+1]} + {1'b0, w_bits[3*g+2]});
    for (int s = 1; s < NG; s = s * 2)
      for (int g = 0; g + s < NG; g = g + 2 * s)
        w_sum[g] = w_sum[g] + w_sum[g+s];
  end

  assign o_pop = w_sum[0];

endmodule

// File: rtl/xnor_popcount_stream.sv
// Streaming binary neuron: per-beat masked XNOR popcount, saturating
// accumulation across beats, thresholded result with valid/ready.
module xnor_popcount_stream
  import xnor_pop_pkg::*;
#(
  parameter int N     = 128,
  parameter int SUM_W = RES_SUM_W,
  parameter int CNT_W = RES_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_w,
  input  logic [N-1:0]     in_mask,
  input  logic             in_last,
  input  logic [SUM_W-1:0] in_thr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_beats
);

  localparam int PW = pop_w(N);

  logic             w_stall, w_take, w_s2_go, w_first, w_sat_acc;
  logic [PW-1:0]    w_pop;
  logic [64:0]      w_add;
  logic [SUM_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_beats_next;

  logic             r_s1_vld, r_s1_last;
  logic [PW-1:0]    r_s1_pop;
  logic [SUM_W-1:0] r_s1_thr;
  logic [SUM_W-1:0] r_acc;
  logic             r_sat, r_cont;
  logic [CNT_W-1:0] r_beats;

  xnor_popcount_masked #(.N(N)) u_pop (
    .i_x    (in_x),
    .i_w    (in_w),
    .i_mask (in_mask),
    .o_pop  (w_pop)
  );

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~rstn & ~w_stall;
  assign w_take   = in_valid & in_ready;
  assign w_s2_go  = r_s1_vld & ~w_stall;
  // r_cont is clear after reset and after a last beat, so the next beat starts fresh.
  assign w_first  = ~r_cont;

  assign w_add        = sat_add(64'(w_first ? {SUM_W{1'b0}} : r_acc), 64'(r_s1_pop), SUM_W);
  assign w_acc_next   = w_add[SUM_W-1:0];
  assign w_sat_acc    = w_add[64] | (~w_first & r_sat);
  assign w_beats_next = w_first ? CNT_W'(1) : r_beats + CNT_W'(1);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_pop  <= '0;
      r_s1_thr  <= '0;
    end else if (!w_stall) begin
      r_s1_vld <= w_take;
      if (w_take) begin
        r_s1_pop  <= w_pop;
        r_s1_last <= in_last;
        if (in_last) r_s1_thr <= in_thr;
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_beats <= '0;
      r_cont  <= 1'b0;
    end else if (w_s2_go) begin
      r_acc   <= w_acc_next;
      r_sat   <= w_sat_acc;
      r_beats <= w_beats_next;
      r_cont  <= ~r_s1_last;
    end
  end

  // A load in the same cycle as a consume keeps out_valid high with new data.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      out_beats <= '0;
    end else if (w_s2_go && r_s1_last) begin
      out_valid <= 1'b1;
      out_bit   <= w_acc_next > r_s1_thr;
      out_sum   <= w_acc_next;
      out_sat   <= w_sat_acc;
      out_beats <= w_beats_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xnor_popcount_stream.sv
// Directed bench: main instance (SUM_W=16) plus a narrow instance (SUM_W=8)
// for accumulator saturation.
module tb_xnor_popcount_stream;

  localparam int N = 128;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N-1:0] x, w, m;
  logic         last;
  logic [15:0]  thr;

  logic        vm, rdym, orm, ovm, obm, satm;
  logic [15:0] summ;
  logic [7:0]  beatsm;

  logic        vs, rdys, ors, ovs, obs, sats;
  logic [7:0]  sums;
  logic [7:0]  beatss;

  int n_chk = 0;
  int n_err = 0;

  xnor_popcount_stream #(.N(N), .SUM_W(16), .CNT_W(8)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(vm), .in_ready(rdym), .in_x(x), .in_w(w),
    .in_mask(m), .in_last(last), .in_thr(thr), .out_valid(ovm), .out_ready(orm),
    .out_bit(obm), .out_sum(summ), .out_sat(satm), .out_beats(beatsm)
  );

  xnor_popcount_stream #(.N(N), .SUM_W(8), .CNT_W(8)) u_sat (
    .clk(clk), .rstn(rstn), .in_valid(vs), .in_ready(rdys), .in_x(x), .in_w(w),
    .in_mask(m), .in_last(last), .in_thr(thr[7:0]), .out_valid(ovs), .out_ready(ors),
    .out_bit(obs), .out_sum(sums), .out_sat(sats), .out_beats(beatss)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] lo(input int k);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < k; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Presents one beat on the selected instance and returns once it will be
  // accepted on the coming rising edge.
  task automatic send(input bit sel, input logic [N-1:0] tx, input logic [N-1:0] tw,
                      input logic [N-1:0] tm, input bit tl, input logic [15:0] tt);
    @(negedge clk);
    x = tx; w = tw; m = tm; last = tl; thr = tt;
    if (sel) vs = 1'b1; else vm = 1'b1;
    for (int i = 0; i < 50 && !(sel ? rdys : rdym); i++) @(negedge clk);
    if (!(sel ? rdys : rdym)) chk("send_timeout", 0, 1);
  endtask

  task automatic drop();
    @(negedge clk);
    vm = 1'b0; vs = 1'b0;
  endtask

  task automatic wait_out(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? ovs : ovm) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!(sel ? ovs : ovm)) chk("out_timeout", 0, 1);
  endtask

  logic [N-1:0] P;
  int lat;

  initial begin
    P = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    rstn = 1'b1; vm = 1'b0; vs = 1'b0; orm = 1'b1; ors = 1'b1;
    x = '0; w = '0; m = '0; last = 1'b0; thr = '0;
    #1;
    chk("rst_in_ready", rdym, 0);
    chk("rst_out_valid", ovm, 0);
    chk("rst_out_sum", summ, 0);
    chk("rst_out_beats", beatsm, 0);
    chk("rst_out_sat", satm, 0);
    chk("rst_sat_in_ready", rdys, 0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b0;
    #1 chk("post_rst_in_ready", rdym, 1);

    // single-beat neuron, full match
    send(0, P, P, '1, 1, 100);
    drop();
    chk("single_lat_early", ovm, 0);
    wait_out(0, lat);
    chk("single_lat", lat, 1);
    chk("single_sum", summ, 128);
    chk("single_bit", obm, 1);
    chk("single_beats", beatsm, 1);
    chk("single_sat", satm, 0);

    // three beats: mismatch, half-word mask, full match; non-last thr ignored
    send(0, ~P, P, '1, 0, 0);
    send(0, P, P, lo(16), 0, 0);
    send(0, P, P, '1, 1, 144);
    drop();
    wait_out(0, lat);
    chk("three_sum", summ, 144);
    chk("three_bit", obm, 0);
    chk("three_beats", beatsm, 3);

    // all-zero mask beat still counts as a beat
    send(0, P, P, '0, 0, 0);
    send(0, P, P, lo(1), 1, 0);
    drop();
    wait_out(0, lat);
    chk("zmask_sum", summ, 1);
    chk("zmask_beats", beatsm, 2);
    chk("zmask_bit", obm, 1);

    // back-to-back single-beat neurons: A=10, B=5 (bit 4 differs)
    send(0, '0, '0, lo(10), 1, 9);
    send(0, 128'h1F, 128'h0F, lo(6), 1, 5);
    drop();
    chk("b2b_a_valid", ovm, 1);
    chk("b2b_a_sum", summ, 10);
    chk("b2b_a_bit", obm, 1);
    @(negedge clk);
    chk("b2b_b_valid", ovm, 1);
    chk("b2b_b_sum", summ, 5);
    chk("b2b_b_bit", obm, 0);
    chk("b2b_b_beats", beatsm, 1);
    @(negedge clk);
    chk("b2b_idle", ovm, 0);

    // backpressure
    orm = 1'b0;
    send(0, '0, '0, lo(20), 1, 5);
    drop();
    wait_out(0, lat);
    chk("bp_sum", summ, 20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      x = '0; w = '0; m = lo(9); last = 1'b1; thr = 100; vm = 1'b1;
      chk("bp_in_ready", rdym, 0);
      chk("bp_valid_hold", ovm, 1);
      chk("bp_sum_hold", summ, 20);
    end
    @(negedge clk);
    orm = 1'b1;
    @(negedge clk);
    vm = 1'b0;
    chk("bp_no_dup", ovm, 0);
    @(negedge clk);
    chk("bp_next_valid", ovm, 1);
    chk("bp_next_sum", summ, 9);
    chk("bp_next_beats", beatsm, 1);
    chk("bp_next_bit", obm, 0);

    // saturation on the 8-bit instance
    send(1, P, P, '1, 0, 0);
    send(1, P, P, '1, 0, 0);
    send(1, P, P, '1, 1, 0);
    drop();
    wait_out(1, lat);
    chk("sat_sum", sums, 255);
    chk("sat_flag", sats, 1);
    chk("sat_beats", beatss, 3);
    chk("sat_bit", obs, 1);
    send(1, '0, '0, lo(3), 1, 0);
    drop();
    wait_out(1, lat);
    chk("after_sat_sum", sums, 3);
    chk("after_sat_flag", sats, 0);
    chk("after_sat_beats", beatss, 1);

    // async reset mid-neuron
    send(0, '0, '0, lo(50), 0, 0);
    send(0, '0, '0, lo(50), 0, 0);
    @(negedge clk);
    vm = 1'b0;
    #1 rstn = 1'b1;
    #1;
    chk("mid_rst_valid", ovm, 0);
    chk("mid_rst_ready", rdym, 0);
    chk("mid_rst_sum", summ, 0);
    chk("mid_rst_sat_sum", sums, 0);
    #1 rstn = 1'b0;
    send(0, '0, '0, lo(7), 1, 3);
    drop();
    wait_out(0, lat);
    chk("post_rst_sum", summ, 7);
    chk("post_rst_beats", beatsm, 1);
    chk("post_rst_bit", obm, 1);
    chk("post_rst_sat", satm, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
